// File: rtl/riscv_rf_wb_arbiter_pkg.sv
// rtl/riscv_rf_wb_arbiter_pkg.sv - shared types, constants and helpers for the RF writeback arbiter
package riscv_rf_wb_pkg;

    // Native register-file geometry; the arbiter parameters default to these.
    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DATA_WIDTH = 32;

    // Number of register-file write ports shared by the writeback sources.
    localparam int RF_WR_PORTS = 2;

    // Writes to this address are architecturally discarded (x0/r0).
    localparam logic [31:0] RF_ZERO_ADDR = '0;

    // One writeback request or one registered port write.
    typedef struct packed {
        logic                     valid;
        logic [RF_ADDR_WIDTH-1:0] waddr;
        logic [RF_DATA_WIDTH-1:0] wdata;
    } wb_req_t;

    // Round-robin successor of idx among n requesters, wrapping n-1 -> 0.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/riscv_rf_wb_arbiter_if.sv
// rtl/riscv_rf_wb_arbiter_if.sv - requester handshake and RF write-port bundle for the writeback arbiter
interface riscv_rf_wb_arbiter_if
    import riscv_rf_wb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH
);

    // Requester side: flattened per-requester fields, requester i at slice i.
    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_waddr_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i;

    // Register-file side: two registered write ports.
    logic                          we_a_o;
    logic [ADDR_WIDTH-1:0]         waddr_a_o;
    logic [DATA_WIDTH-1:0]         wdata_a_o;
    logic                          we_b_o;
    logic [ADDR_WIDTH-1:0]         waddr_b_o;
    logic [DATA_WIDTH-1:0]         wdata_b_o;

    // Some valid requester was left waiting this cycle.
    logic                          stall_o;

    // Writeback sources drive requests and observe acceptance and the ports.
    modport master (
        output req_valid_i, req_waddr_i, req_wdata_i,
        input  req_ready_o, stall_o,
        input  we_a_o, waddr_a_o, wdata_a_o,
        input  we_b_o, waddr_b_o, wdata_b_o
    );

    // The arbiter consumes requests and drives acceptance and the ports.
    modport slave (
        input  req_valid_i, req_waddr_i, req_wdata_i,
        output req_ready_o, stall_o,
        output we_a_o, waddr_a_o, wdata_a_o,
        output we_b_o, waddr_b_o, wdata_b_o
    );

endinterface

// File: rtl/riscv_rf_wb_rr_pick.sv
// rtl/riscv_rf_wb_rr_pick.sv - combinational rotate-priority picker (first request at or after start)
module riscv_rf_wb_rr_pick #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          found,
    output logic [IW-1:0] idx
);

    // Lowest request index >= start wins; otherwise wrap and take the lowest overall.
    // Loops run high-to-low so the last assignment is the lowest matching index.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req[j] && (IW'(j) >= start)) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
        if (!found) begin
            for (int j = N - 1; j >= 0; j--) begin
                if (req[j]) begin
                    found = 1'b1;
                    idx   = IW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/riscv_rf_wb_arbiter.sv
// rtl/riscv_rf_wb_arbiter.sv - round-robin arbiter of writeback sources onto two RF write ports (option: RF_WB_ARB_PERF_EN)
module riscv_rf_wb_arbiter
    import riscv_rf_wb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    riscv_rf_wb_arbiter_if.slave bus
`ifdef RF_WB_ARB_PERF_EN
    ,
    output logic [31:0]          perf_stall_cnt_o,
    output logic [31:0]          perf_dual_cnt_o
`endif
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [ADDR_WIDTH-1:0] addr [NUM_REQ];
    logic [DATA_WIDTH-1:0] data [NUM_REQ];
    logic [NUM_REQ-1:0]    nz_valid;
    logic [NUM_REQ-1:0]    cand1;
    logic [NUM_REQ-1:0]    ready;

    logic                  g0_found;
    logic                  g1_found;
    logic [IW-1:0]         g0_idx;
    logic [IW-1:0]         g1_idx;
    logic [IW-1:0]         rr_q;
    logic [IW-1:0]         rr_d;

    // Registered port state; index 0 is port A, index 1 is port B.
    logic [RF_WR_PORTS-1:0] we_q;
    logic [ADDR_WIDTH-1:0]  waddr_q [RF_WR_PORTS];
    logic [DATA_WIDTH-1:0]  wdata_q [RF_WR_PORTS];

    // Per-requester view of the flattened buses. r0 writes never compete for a port,
    // and only a nonzero grant 0 can block a colliding address from grant 1.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign addr[gi]     = bus.req_waddr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign data[gi]     = bus.req_wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
        assign nz_valid[gi] = bus.req_valid_i[gi] &&
                              (addr[gi] != RF_ZERO_ADDR[ADDR_WIDTH-1:0]);
        // Differing address also excludes grant 0 itself; empty when there is no grant 0.
        assign cand1[gi]    = nz_valid[gi] && (addr[gi] != addr[g0_idx]);
        assign ready[gi]    = bus.req_valid_i[gi] &&
                              (!nz_valid[gi] ||
                               (g0_found && (g0_idx == IW'(gi))) ||
                               (g1_found && (g1_idx == IW'(gi))));
    end

    riscv_rf_wb_rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick0 (
        .req   (nz_valid),
        .start (rr_q),
        .found (g0_found),
        .idx   (g0_idx)
    );

    riscv_rf_wb_rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick1 (
        .req   (cand1),
        .start (rr_q),
        .found (g1_found),
        .idx   (g1_idx)
    );

    assign bus.req_ready_o = ready;
    assign bus.stall_o     = |(bus.req_valid_i & ~ready);

    // Next round-robin start: one past the last nonzero grant, else unchanged.
    always_comb begin
        rr_d = rr_q;
        if (g1_found) begin
            rr_d = IW'(rr_next(32'(g1_idx), NUM_REQ));
        end else if (g0_found) begin
            rr_d = IW'(rr_next(32'(g0_idx), NUM_REQ));
        end
    end

    // Pointer and port register stage; idle ports drop we but keep address/data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q       <= '0;
            we_q       <= '0;
            waddr_q[0] <= '0;
            wdata_q[0] <= '0;
            waddr_q[1] <= '0;
            wdata_q[1] <= '0;
        end else begin
            rr_q <= rr_d;
            we_q <= {g1_found, g0_found};
            if (g0_found) begin
                waddr_q[0] <= addr[g0_idx];
                wdata_q[0] <= data[g0_idx];
            end
            if (g1_found) begin
                waddr_q[1] <= addr[g1_idx];
                wdata_q[1] <= data[g1_idx];
            end
        end
    end

    assign bus.we_a_o    = we_q[0];
    assign bus.waddr_a_o = waddr_q[0];
    assign bus.wdata_a_o = wdata_q[0];
    assign bus.we_b_o    = we_q[1];
    assign bus.waddr_b_o = waddr_q[1];
    assign bus.wdata_b_o = wdata_q[1];

`ifdef RF_WB_ARB_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] dual_cnt_q;

    // Saturating event counters; a dual write is counted in the cycle the pair is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            dual_cnt_q  <= '0;
        end else begin
            if (bus.stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (g0_found && g1_found && (dual_cnt_q != 32'hFFFF_FFFF)) begin
                dual_cnt_q <= dual_cnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt_o = stall_cnt_q;
    assign perf_dual_cnt_o  = dual_cnt_q;
`endif

endmodule

// File: tb/tb_riscv_rf_wb_arbiter.sv
// tb/tb_riscv_rf_wb_arbiter.sv - scoreboard bench for the RF writeback arbiter
module tb_riscv_rf_wb_arbiter;
    import riscv_rf_wb_pkg::*;

    localparam int NR = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    typedef struct {
        wb_req_t a;
        wb_req_t b;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    riscv_rf_wb_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef RF_WB_ARB_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_dual_cnt;
`endif

    riscv_rf_wb_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus)
`ifdef RF_WB_ARB_PERF_EN
        ,
        .perf_stall_cnt_o (perf_stall_cnt),
        .perf_dual_cnt_o  (perf_dual_cnt)
`endif
    );

    int            n_checks = 0;
    int            n_errors = 0;
    logic [AW-1:0] t_addr [NR];
    logic [DW-1:0] t_data [NR];
    logic [NR-1:0] t_valid;
    logic [NR-1:0] last_ready;
    int            m_rr;
    wb_req_t       held_a;
    wb_req_t       held_b;
    exp_t          sb_q [$];
    int            wait_cnt [NR];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        bus.req_valid_i = t_valid;
        for (int i = 0; i < NR; i++) begin
            bus.req_waddr_i[i*AW +: AW] = t_addr[i];
            bus.req_wdata_i[i*DW +: DW] = t_data[i];
        end
    endtask

    function automatic logic [AW-1:0] fresh_addr(input int self);
        logic [AW-1:0] a;
        bit            clash;
        do begin
            a     = AW'($urandom_range(1, 31));
            clash = 1'b0;
            for (int k = 0; k < NR; k++)
                if (k != self && t_addr[k] == a) clash = 1'b1;
        end while (clash);
        return a;
    endfunction

    // One arbitration cycle: model the grants at negedge, queue the port state, check after the edge.
    task automatic step(input logic [NR-1:0] want, input bit use_want);
        int            g0;
        int            g1;
        int            j;
        logic [NR-1:0] er;
        exp_t          e;
        drive();
        @(negedge clk);
        g0 = -1;
        g1 = -1;
        er = '0;
        for (int k = 0; k < NR; k++) begin
            j = (m_rr + k) % NR;
            if (t_valid[j]) begin
                if (t_addr[j] == 0) begin
                    er[j] = 1'b1;
                end else if (g0 < 0) begin
                    g0 = j;
                    er[j] = 1'b1;
                end else if (g1 < 0 && t_addr[j] != t_addr[g0]) begin
                    g1 = j;
                    er[j] = 1'b1;
                end
            end
        end
        check("ready", 64'(bus.req_ready_o), 64'(er));
        if (use_want) check("ready_dir", 64'(bus.req_ready_o), 64'(want));
        check("stall", 64'(bus.stall_o), 64'(|(t_valid & ~er)));
        e.a = held_a;
        e.a.valid = 1'b0;
        e.b = held_b;
        e.b.valid = 1'b0;
        if (g0 >= 0) e.a = '{valid: 1'b1, waddr: t_addr[g0], wdata: t_data[g0]};
        if (g1 >= 0) e.b = '{valid: 1'b1, waddr: t_addr[g1], wdata: t_data[g1]};
        held_a = e.a;
        held_b = e.b;
        if (g1 >= 0) m_rr = (g1 + 1) % NR;
        else if (g0 >= 0) m_rr = (g0 + 1) % NR;
        sb_q.push_back(e);
        last_ready = bus.req_ready_o;
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("we_a",    64'(bus.we_a_o),    64'(e.a.valid));
        check("waddr_a", 64'(bus.waddr_a_o), 64'(e.a.waddr));
        check("wdata_a", 64'(bus.wdata_a_o), 64'(e.a.wdata));
        check("we_b",    64'(bus.we_b_o),    64'(e.b.valid));
        check("waddr_b", 64'(bus.waddr_b_o), 64'(e.b.waddr));
        check("wdata_b", 64'(bus.wdata_b_o), 64'(e.b.wdata));
    endtask

    // Reset can land mid-write: ports must clear at once, without waiting for a clock.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_we_a",    64'(bus.we_a_o),    64'(0));
        check("rst_we_b",    64'(bus.we_b_o),    64'(0));
        check("rst_waddr_a", 64'(bus.waddr_a_o), 64'(0));
        check("rst_wdata_a", 64'(bus.wdata_a_o), 64'(0));
        check("rst_waddr_b", 64'(bus.waddr_b_o), 64'(0));
        check("rst_wdata_b", 64'(bus.wdata_b_o), 64'(0));
        t_valid = '0;
        drive();
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        m_rr   = 0;
        held_a = '0;
        held_b = '0;
        sb_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        t_valid = '0;
        for (int i = 0; i < NR; i++) begin
            t_addr[i] = '0;
            t_data[i] = '0;
        end
        drive();
        do_reset();

        // Single request on port A.
        t_valid   = 3'b001;
        t_addr[0] = 5'd5;
        t_data[0] = 32'hDEAD_BEEF;
        step(3'b001, 1'b1);
        check("t2_we_a",    64'(bus.we_a_o),    64'(1));
        check("t2_waddr_a", 64'(bus.waddr_a_o), 64'(5));
        check("t2_wdata_a", 64'(bus.wdata_a_o), 64'(32'hDEAD_BEEF));
        check("t2_we_b",    64'(bus.we_b_o),    64'(0));
        t_valid = '0;

        // Reset while the write above is on port A.
        do_reset();

        // Three-way contention from rr=0.
        t_valid = 3'b111;
        for (int i = 0; i < NR; i++) begin
            t_addr[i] = AW'(i + 1);
            t_data[i] = $urandom();
        end
        step(3'b011, 1'b1);
        t_valid = 3'b100;
        step(3'b100, 1'b1);
        t_valid = '0;
        step(3'b000, 1'b1);

        // Address collision: only the first of two same-address writers goes.
        t_valid   = 3'b011;
        t_addr[0] = 5'd7;
        t_addr[1] = 5'd7;
        t_data[0] = 32'h1111_0000;
        t_data[1] = 32'h2222_0000;
        step(3'b001, 1'b1);
        t_valid = 3'b010;
        step(3'b010, 1'b1);
        t_valid = '0;

        // r0 write accepted without a port.
        do_reset();
        t_valid   = 3'b111;
        t_addr[0] = 5'd4;
        t_addr[1] = 5'd0;
        t_addr[2] = 5'd9;
        t_data[0] = 32'hA0A0_0004;
        t_data[1] = 32'hB0B0_0000;
        t_data[2] = 32'hC0C0_0009;
        step(3'b111, 1'b1);
        check("t5_waddr_a", 64'(bus.waddr_a_o), 64'(4));
        check("t5_waddr_b", 64'(bus.waddr_b_o), 64'(9));
        t_valid = '0;

        // Fairness under continuous contention.
        do_reset();
`ifdef RF_WB_ARB_PERF_EN
        check("perf_stall_rst", 64'(perf_stall_cnt), 64'(0));
        check("perf_dual_rst",  64'(perf_dual_cnt),  64'(0));
`endif
        for (int i = 0; i < NR; i++) t_addr[i] = '0;
        for (int i = 0; i < NR; i++) begin
            t_addr[i]   = fresh_addr(i);
            t_data[i]   = $urandom();
            wait_cnt[i] = 0;
        end
        t_valid = 3'b111;
        for (int c = 0; c < 30; c++) begin
            step('0, 1'b0);
            for (int i = 0; i < NR; i++) begin
                if (last_ready[i]) begin
                    wait_cnt[i] = 0;
                    t_addr[i]   = fresh_addr(i);
                    t_data[i]   = $urandom();
                end else begin
                    wait_cnt[i]++;
                    check("starve", 64'(wait_cnt[i] <= NR - 2), 64'(1));
                end
            end
        end
`ifdef RF_WB_ARB_PERF_EN
        check("perf_dual_30",  64'(perf_dual_cnt),  64'(30));
        check("perf_stall_30", 64'(perf_stall_cnt), 64'(30));
`endif
        t_valid = '0;
        drive();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
